// File: rtl/dmem_pkg.sv
// Shared size codes, clear-FSM encoding and byte-lane helpers for data_memory_bytelane.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } clrState_t;

  // Byte enables for a store of the given size at the given lane (little-endian)
  function automatic logic [BE_W-1:0] laneEnable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      SZ_WORD: return lane == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Replicate right-justified store data across lanes so byte enables pick the right copy
  function automatic logic [WORD_W-1:0] laneData(input logic [1:0] size, input logic [WORD_W-1:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects byte/half/word from a memory word and sign/zero extends.
module load_align
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] memWord,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              signedLd,
  output logic [WORD_W-1:0] result_c
);

  logic [WORD_W-1:0] shifted;

  assign shifted = memWord >> {lane, 3'b000};

  always_comb begin
    result_c = '0;
    case (size)
      SZ_BYTE: result_c = {{24{signedLd & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_c = {{16{signedLd & shifted[15]}}, shifted[15:0]};
      default: result_c = memWord;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressable MEM-stage data memory with lane-masked stores and 1-cycle extended loads.
// Optional power-on clear sweep enabled with `define DMEM_CLEAR_EN.
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              req,
  input  logic              wrEnable,
  input  logic [1:0]        size,
  input  logic              signedLd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              misalign
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  if (DATA_W != WORD_W) begin : gDataWCheck
    $error("data_memory_bytelane: DATA_W must be 32");
  end

  logic [WORD_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  wordIdx;
  logic [1:0]        lane;
  logic              accept;
  logic              aligned;
  logic              doStore;
  logic              doLoad;
  logic              readyNext;
  logic [BE_W-1:0]   byteEn;
  logic [WORD_W-1:0] storeData;
  logic [WORD_W-1:0] ldResult;

  logic              memWe;
  logic [IDX_W-1:0]  memIdx;
  logic [BE_W-1:0]   memBe;
  logic [WORD_W-1:0] memData;

  assign wordIdx   = addr[ADDR_W-1:2];
  assign lane      = addr[1:0];
  assign accept    = rst_n & req & ready;
  assign aligned   = isAligned(size, lane);
  assign doStore   = accept & wrEnable & aligned;
  assign doLoad    = accept & ~wrEnable & aligned;
  assign byteEn    = laneEnable(size, lane);
  assign storeData = laneData(size, wrData);

  load_align uAlign (
    .memWord  (mem[wordIdx]),
    .lane     (lane),
    .size     (size),
    .signedLd (signedLd),
    .result_c (ldResult)
  );

`ifdef DMEM_CLEAR_EN
  clrState_t        state;
  clrState_t        stateNext;
  logic [IDX_W-1:0] clrIdx;
  logic [IDX_W-1:0] clrIdxNext;
  logic             clrWrite;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_RST;
      clrIdx <= '0;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
    end
  end

  // Sweep zeros through every word once after reset, then accept traffic
  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    clrWrite   = 1'b0;
    case (state)
      ST_RST: stateNext = ST_CLEAR;
      ST_CLEAR: begin
        clrWrite   = rst_n;
        clrIdxNext = IDX_W'(clrIdx + 1'b1);
        if (clrIdx == IDX_W'(DEPTH - 1)) stateNext = ST_RUN;
      end
      ST_RUN: stateNext = ST_RUN;
      default: stateNext = ST_RST;
    endcase
  end

  assign readyNext = (stateNext == ST_RUN);
`else
  assign readyNext = 1'b1;
`endif

  // Single write port shared by stores and (optionally) the clear sweep
  always_comb begin
    memWe   = doStore;
    memIdx  = wordIdx;
    memBe   = byteEn;
    memData = storeData;
`ifdef DMEM_CLEAR_EN
    if (clrWrite) begin
      memWe   = 1'b1;
      memIdx  = clrIdx;
      memBe   = '1;
      memData = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (memBe[b]) mem[memIdx][8*b +: 8] <= memData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      rdValid  <= 1'b0;
      misalign <= 1'b0;
      rdData   <= '0;
    end else begin
      ready    <= readyNext;
      rdValid  <= doLoad;
      misalign <= accept & ~aligned;
      if (doLoad) rdData <= ldResult;
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed self-checking bench for data_memory_bytelane (default build and DMEM_CLEAR_EN build).
module tb_data_memory_bytelane;
  import dmem_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << (ADDR_W - 2);
`ifdef DMEM_CLEAR_EN
  localparam int          EXP_ZEROS  = DEPTH;
  localparam logic [31:0] EXP_NOTRDY = 32'h0000_0000;
`else
  localparam int          EXP_ZEROS  = 0;
  localparam logic [31:0] EXP_NOTRDY = 32'h1111_1111;
`endif

  typedef struct packed {
    logic [1:0]  sz;
    logic        sgn;
    logic [9:0]  a;
    logic [31:0] exp;
  } ldVec_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        sgn;
    logic [9:0]  a;
    logic [31:0] d;
    logic        expValid;
    logic [31:0] exp;
  } accVec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ready;
  logic              req;
  logic              wrEnable;
  logic [1:0]        size;
  logic              signedLd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wrData;
  logic [31:0]       rdData;
  logic              rdValid;
  logic              misalign;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  data_memory_bytelane #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .req      (req),
    .wrEnable (wrEnable),
    .size     (size),
    .signedLd (signedLd),
    .addr     (addr),
    .wrData   (wrData),
    .rdData   (rdData),
    .rdValid  (rdValid),
    .misalign (misalign)
  );

  // Drive one access at a falling edge; returns at the next falling edge with its response visible
  task automatic doAcc(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
    req = 1'b1; wrEnable = we; size = sz; signedLd = sgn; addr = a; wrData = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic waitReady(output int zeros);
    zeros = 0;
    @(negedge clk);
    while (ready !== 1'b1 && zeros < 2000) begin
      zeros++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int z;
    rst_n = 1'b0; req = 1'b0; wrEnable = 1'b0; size = SZ_WORD; signedLd = 1'b0;
    addr = '0; wrData = '0;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passed++;
    total++; if (rdValid !== 1'b0) $display("FAIL reset_rdValid: got %b expected 0", rdValid); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b expected 0", misalign); else passed++;
    total++; if (rdData !== 32'h0) $display("FAIL reset_rdData: got %h expected 00000000", rdData); else passed++;
    rst_n = 1'b1;
    waitReady(z);
    total++; if (z !== EXP_ZEROS) $display("FAIL reset_ready_delay: got %0d cycles expected %0d", z, EXP_ZEROS); else passed++;
  endtask

  task automatic test_store_load();
    doAcc(1'b1, SZ_WORD, 1'b0, 10'h010, 32'h8899AABB);
    total++;
    if (rdValid !== 1'b0 || misalign !== 1'b0)
      $display("FAIL sw_noresp: rdValid=%b misalign=%b expected 0 0", rdValid, misalign);
    else passed++;
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0);
    total++;
    if (rdValid !== 1'b1 || rdData !== 32'h8899AABB)
      $display("FAIL lw_010: rdValid=%b rdData=%h expected 1 8899aabb", rdValid, rdData);
    else passed++;
    @(negedge clk);
    total++;
    if (rdValid !== 1'b0 || rdData !== 32'h8899AABB)
      $display("FAIL lw_hold: rdValid=%b rdData=%h expected 0 8899aabb", rdValid, rdData);
    else passed++;
  endtask

  task automatic test_byte();
    ldVec_t v [6];
    v = '{'{SZ_WORD, 1'b0, 10'h010, 32'hF099AABB},
          '{SZ_BYTE, 1'b1, 10'h013, 32'hFFFFFFF0},
          '{SZ_BYTE, 1'b0, 10'h013, 32'h000000F0},
          '{SZ_BYTE, 1'b1, 10'h010, 32'hFFFFFFBB},
          '{SZ_BYTE, 1'b0, 10'h011, 32'h000000AA},
          '{SZ_BYTE, 1'b1, 10'h012, 32'hFFFFFF99}};
    doAcc(1'b1, SZ_BYTE, 1'b0, 10'h013, 32'h000000F0);
    for (int i = 0; i < 6; i++) begin
      doAcc(1'b0, v[i].sz, v[i].sgn, v[i].a, 32'h0);
      total++;
      if (rdValid !== 1'b1 || rdData !== v[i].exp)
        $display("FAIL byte_load[%0d]: rdValid=%b rdData=%h expected 1 %h", i, rdValid, rdData, v[i].exp);
      else passed++;
    end
    doAcc(1'b1, SZ_BYTE, 1'b0, 10'h011, 32'hFFFFFF55);
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0);
    total++;
    if (rdValid !== 1'b1 || rdData !== 32'hF09955BB)
      $display("FAIL sb_upper_ignored: rdValid=%b rdData=%h expected 1 f09955bb", rdValid, rdData);
    else passed++;
  endtask

  task automatic test_half();
    ldVec_t v [5];
    v = '{'{SZ_HALF, 1'b1, 10'h012, 32'hFFFF8001},
          '{SZ_HALF, 1'b0, 10'h012, 32'h00008001},
          '{SZ_HALF, 1'b1, 10'h010, 32'h000055BB},
          '{SZ_HALF, 1'b0, 10'h010, 32'h000055BB},
          '{SZ_WORD, 1'b0, 10'h010, 32'h800155BB}};
    doAcc(1'b1, SZ_HALF, 1'b0, 10'h012, 32'h00008001);
    for (int i = 0; i < 5; i++) begin
      doAcc(1'b0, v[i].sz, v[i].sgn, v[i].a, 32'h0);
      total++;
      if (rdValid !== 1'b1 || rdData !== v[i].exp)
        $display("FAIL half_load[%0d]: rdValid=%b rdData=%h expected 1 %h", i, rdValid, rdData, v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_misalign();
    accVec_t v [7];
    v = '{'{1'b0, SZ_HALF, 1'b1, 10'h011, 32'h0,        1'b0, 32'h0},
          '{1'b1, SZ_WORD, 1'b0, 10'h012, 32'hDEADBEEF, 1'b0, 32'h0},
          '{1'b1, SZ_HALF, 1'b0, 10'h013, 32'h00001234, 1'b0, 32'h0},
          '{1'b1, SZ_WORD, 1'b0, 10'h011, 32'h55555555, 1'b0, 32'h0},
          '{1'b0, SZ_WORD, 1'b0, 10'h002, 32'h0,        1'b0, 32'h0},
          '{1'b0, 2'b11,   1'b0, 10'h010, 32'h0,        1'b0, 32'h0},
          '{1'b1, 2'b11,   1'b0, 10'h010, 32'h0,        1'b0, 32'h0}};
    for (int i = 0; i < 7; i++) begin
      doAcc(v[i].we, v[i].sz, v[i].sgn, v[i].a, v[i].d);
      total++;
      if (misalign !== 1'b1 || rdValid !== 1'b0 || rdData !== 32'h800155BB)
        $display("FAIL misalign[%0d]: misalign=%b rdValid=%b rdData=%h expected 1 0 800155bb",
                 i, misalign, rdValid, rdData);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (misalign !== 1'b0) $display("FAIL misalign_pulse: got %b expected 0", misalign); else passed++;
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0);
    total++;
    if (rdValid !== 1'b1 || rdData !== 32'h800155BB || misalign !== 1'b0)
      $display("FAIL misalign_nowrite: rdValid=%b rdData=%h misalign=%b expected 1 800155bb 0",
               rdValid, rdData, misalign);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    accVec_t v [11];
    v = '{'{1'b1, SZ_WORD, 1'b0, 10'h3FC, 32'hCAFEF00D, 1'b0, 32'h800155BB},
          '{1'b1, SZ_WORD, 1'b0, 10'h000, 32'h01234567, 1'b0, 32'h800155BB},
          '{1'b0, SZ_WORD, 1'b0, 10'h3FC, 32'h0,        1'b1, 32'hCAFEF00D},
          '{1'b1, SZ_BYTE, 1'b0, 10'h3FD, 32'h00000077, 1'b0, 32'hCAFEF00D},
          '{1'b0, SZ_WORD, 1'b0, 10'h3FC, 32'h0,        1'b1, 32'hCAFE770D},
          '{1'b0, SZ_HALF, 1'b1, 10'h3FE, 32'h0,        1'b1, 32'hFFFFCAFE},
          '{1'b0, SZ_BYTE, 1'b0, 10'h3FF, 32'h0,        1'b1, 32'h000000CA},
          '{1'b0, SZ_WORD, 1'b0, 10'h000, 32'h0,        1'b1, 32'h01234567},
          '{1'b1, SZ_HALF, 1'b0, 10'h002, 32'h0000BEEF, 1'b0, 32'h01234567},
          '{1'b0, SZ_HALF, 1'b0, 10'h002, 32'h0,        1'b1, 32'h0000BEEF},
          '{1'b0, SZ_WORD, 1'b0, 10'h000, 32'h0,        1'b1, 32'hBEEF4567}};
    for (int i = 0; i < 11; i++) begin
      doAcc(v[i].we, v[i].sz, v[i].sgn, v[i].a, v[i].d);
      total++;
      if (rdValid !== v[i].expValid || rdData !== v[i].exp)
        $display("FAIL b2b[%0d]: rdValid=%b rdData=%h expected %b %h",
                 i, rdValid, rdData, v[i].expValid, v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_not_ready();
    int z;
    doAcc(1'b1, SZ_WORD, 1'b0, 10'h020, 32'h11111111);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    doAcc(1'b1, SZ_WORD, 1'b0, 10'h020, 32'h22222222);
    total++;
    if (rdValid !== 1'b0 || misalign !== 1'b0)
      $display("FAIL notready_noresp: rdValid=%b misalign=%b expected 0 0", rdValid, misalign);
    else passed++;
    waitReady(z);
    total++; if (ready !== 1'b1) $display("FAIL notready_ready: got %b expected 1", ready); else passed++;
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0);
    total++;
    if (rdValid !== 1'b1 || rdData !== EXP_NOTRDY)
      $display("FAIL notready_nowrite: rdValid=%b rdData=%h expected 1 %h", rdValid, rdData, EXP_NOTRDY);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int z;
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0);
    rst_n = 1'b0;
    doAcc(1'b0, SZ_HALF, 1'b0, 10'h011, 32'h0);
    total++;
    if (rdValid !== 1'b0 || misalign !== 1'b0 || rdData !== 32'h0 || ready !== 1'b0)
      $display("FAIL midreset: rdValid=%b misalign=%b rdData=%h ready=%b expected 0 0 00000000 0",
               rdValid, misalign, rdData, ready);
    else passed++;
    rst_n = 1'b1;
    waitReady(z);
    total++;
    if (ready !== 1'b1 || z !== EXP_ZEROS)
      $display("FAIL midreset_recover: ready=%b delay=%0d expected 1 %0d", ready, z, EXP_ZEROS);
    else passed++;
  endtask

`ifdef DMEM_CLEAR_EN
  task automatic test_clear();
    int z;
    doAcc(1'b1, SZ_WORD, 1'b0, 10'h3FC, 32'h12345678);
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h3FC, 32'h0);
    total++;
    if (rdData !== 32'h12345678) $display("FAIL clear_preload: got %h expected 12345678", rdData); else passed++;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    waitReady(z);
    total++; if (z !== int'(DEPTH)) $display("FAIL clear_cycles: got %0d expected %0d", z, DEPTH); else passed++;
    doAcc(1'b0, SZ_WORD, 1'b0, 10'h3FC, 32'h0);
    total++;
    if (rdValid !== 1'b1 || rdData !== 32'h0)
      $display("FAIL clear_top: rdValid=%b rdData=%h expected 1 00000000", rdValid, rdData);
    else passed++;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (ready !== 1'b0) $display("FAIL clear_mid_ready: got %b expected 0", ready); else passed++;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    waitReady(z);
    total++; if (z !== int'(DEPTH)) $display("FAIL clear_restart: got %0d expected %0d", z, DEPTH); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_not_ready();
    test_mid_reset();
`ifdef DMEM_CLEAR_EN
    test_clear();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
